// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
);
  localparam int NW = $clog2(DIGITS + 1);

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
  logic [NW-1:0]         ndigits;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf, ndigits
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf, ndigits
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock,
// with sticky overflow and a significant-digit count.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  bin_to_bcd_seq_if.slave    bus
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]   work_q, work_d;
  logic            sticky_q, sticky_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [NW-1:0]   nd_q, nd_d;

  logic [BW-1:0]   adj;
  logic            shout;
  logic [NW-1:0]   nd_f;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    nd_d     = nd_q;
    adj      = work_q;
    shout    = 1'b0;
    nd_f     = NW'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d    = bus.bin_in;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(BIN_W);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        {shout, work_d} = {adj, bin_q[BIN_W-1]};
        bin_d    = {bin_q[BIN_W-2:0], 1'b0};
        sticky_d = sticky_q | shout;
        cnt_d    = cnt_q - CW'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (work_d[4*i +: 4] != 4'd0) nd_f = NW'(i + 1);
        end
        // Result registers load on the edge into FINISH so they are already
        // valid during the done cycle.
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = work_d;
          ovf_d   = sticky_d;
          nd_d    = nd_f;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      nd_q     <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      nd_q     <= nd_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
  assign bus.ndigits = nd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three parameterisations, directed
// handshake/overflow/reset cases and a random sweep against an arithmetic model.
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic [2:0]  st;
  logic [31:0] bin;
  int          sel;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5))  ifa ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4))  ifb ();
  bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(10)) ifc ();

  assign ifa.start  = st[0];
  assign ifb.start  = st[1];
  assign ifc.start  = st[2];
  assign ifa.bin_in = bin[15:0];
  assign ifb.bin_in = bin[15:0];
  assign ifc.bin_in = bin;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5))  dut_a (.Clk(clk), .Reset_n(rst_a), .bus(ifa));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4))  dut_b (.Clk(clk), .Reset_n(rst_b), .bus(ifb));
  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut_c (.Clk(clk), .Reset_n(rst_c), .bus(ifc));

  logic        o_busy, o_done, o_ovf;
  logic [39:0] o_bcd;
  logic [3:0]  o_nd;

  always_comb begin
    case (sel)
      0: begin
        o_busy = ifa.busy; o_done = ifa.done; o_ovf = ifa.ovf;
        o_bcd = 40'(ifa.bcd_out); o_nd = 4'(ifa.ndigits);
      end
      1: begin
        o_busy = ifb.busy; o_done = ifb.done; o_ovf = ifb.ovf;
        o_bcd = 40'(ifb.bcd_out); o_nd = 4'(ifb.ndigits);
      end
      default: begin
        o_busy = ifc.busy; o_done = ifc.done; o_ovf = ifc.ovf;
        o_bcd = ifc.bcd_out; o_nd = ifc.ndigits;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: value modulo 10^dg, digit by digit.
  function automatic void model(input longint unsigned v, input int dg,
                                output logic [39:0] bcd, output logic ovf, output int nd);
    longint unsigned m, r, dd;
    m = 1;
    for (int i = 0; i < dg; i++) m = m * 10;
    ovf = (v >= m);
    r   = v % m;
    bcd = '0;
    nd  = 1;
    for (int i = 0; i < dg; i++) begin
      dd = r % 10;
      bcd[4*i +: 4] = dd[3:0];
      if (dd != 0) nd = i + 1;
      r = r / 10;
    end
  endfunction

  task automatic run(input int s, input longint unsigned v, input int glitch);
    int          bw, dg, cyc;
    logic        busy_ok;
    logic [39:0] eb;
    logic        eo;
    int          en;
    bw  = (s == 2) ? 32 : 16;
    dg  = (s == 0) ? 5 : (s == 1) ? 4 : 10;
    sel = s;
    @(negedge clk);
    bin   = v[31:0];
    st    = '0;
    st[s] = 1'b1;
    busy_ok = 1'b1;
    cyc = 0;
    while (cyc < bw + 5) begin
      @(negedge clk);
      cyc++;
      st  = '0;
      bin = $urandom;
      if (cyc == glitch) begin
        st[s] = 1'b1;
        bin   = 32'd777;
      end
      if (o_done) break;
      if (!o_busy) busy_ok = 1'b0;
    end
    st = '0;
    if (bw == 16) v = v & 64'hFFFF;
    model(v, dg, eb, eo, en);
    chk("latency", 64'(cyc), 64'(bw + 1));
    chk("busy_during", 64'(busy_ok), 64'd1);
    chk("busy_at_done", 64'(o_busy), 64'd0);
    chk("bcd", 64'(o_bcd), 64'(eb));
    chk("ovf", 64'(o_ovf), 64'(eo));
    chk("ndigits", 64'(o_nd), 64'(en));
  endtask

  task automatic watch(input int n, input logic [39:0] hold);
    logic seen, stable;
    seen = 1'b0;
    stable = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
      if (o_bcd !== hold) stable = 1'b0;
    end
    chk("no_extra_done", 64'(seen), 64'd0);
    chk("held", 64'(stable), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    longint unsigned v;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    st = '0; bin = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_bcd", 64'(o_bcd), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_nd", 64'(o_nd), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // 16-bit / 5 digits: zero, max, back-to-back
    run(0, 0, 0);
    run(0, 65535, 0);
    run(0, 1234, 0);
    watch(5, 40'h01234);

    // start pulsed while busy is ignored
    run(0, 500, 5);
    watch(20, 40'h00500);

    // async reset mid-conversion
    sel = 0;
    @(negedge clk);
    bin = 32'd4321;
    st  = 3'b001;
    @(negedge clk);
    st  = '0;
    repeat (7) @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_bcd", 64'(o_bcd), 64'd0);
    chk("midrst_ovf", 64'(o_ovf), 64'd0);
    chk("midrst_nd", 64'(o_nd), 64'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    watch(25, 40'h0);
    run(0, 42, 0);

    // 16-bit / 4 digits: overflow boundaries
    run(1, 65535, 0);
    run(1, 9999, 0);
    run(1, 10000, 0);

    // 32-bit / 10 digits
    run(2, 64'hFFFF_FFFF, 0);
    run(2, 64'd1_000_000_000, 0);
    for (int k = 0; k < 1000; k++) begin
      v = longint'($urandom) >> $urandom_range(0, 31);
      run(2, v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock.
- Input: BIN_W-bit binary word, loaded in parallel on a start/busy/done handshake.
- Outputs: DIGITS packed BCD digits, an overflow flag and a significant-digit count.
- Feeds the seven-segment/display path and the UART decimal formatter.

Parameters:
BIN_W, 32, width of the binary operand (>=2).
DIGITS, 10, number of 4-bit BCD output digits (>=1). It may be smaller than ceil(BIN_W*log10(2)); overflow is then flagged.
CW, $clog2(BIN_W+1), width of the internal bit counter (derived; not overridden).
NW, $clog2(DIGITS+1), width of ndigits (derived).

Ports:
Clk  input  1  clock, rising-edge.
Reset_n  input  1  asynchronous active-low reset.
start  input  1  request conversion of bin_in; sampled only in IDLE.
bin_in  input  BIN_W  binary operand, captured on the accepted start cycle.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse; bcd_out/ovf/ndigits are valid and updated that cycle.
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in [3:0]. Held until the next done.
ovf  output  1  result does not fit in DIGITS digits. Held with bcd_out.
ndigits  output  NW  number of significant digits in bcd_out (1 for value 0). Held with bcd_out.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; busy=0, done=0, bcd_out=0, ovf=0, ndigits=0.
  - Internal shift/BCD/counter registers cleared.
  - Takes effect immediately, including mid-conversion. The partial result is discarded and no done is issued.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 => capture bin_in into the binary shift register.
  - Clear the BCD working register (4*DIGITS bits) and the sticky overflow bit.
  - Set counter=BIN_W and go to SHIFT; busy=1 from the next cycle.
- SHIFT, each cycle, in this order within one clock:
  - (a) Every working digit >=5 gets +3 (4-bit add, no carry between digits).
  - (b) Shift the {BCD, binary} concatenation left by 1, binary MSB entering BCD bit 0.
  - (c) A 1 shifted out of BCD bit 4*DIGITS-1 sets sticky overflow.
  - (d) counter decrements.
  - When counter reaches 1 in SHIFT, the final shift happens that cycle; next state is FINISH.
  - The adjust is applied before the shift, so a digit never exceeds 9 after any shift.
- FINISH (one cycle):
  - Register bcd_out <= working BCD and ovf <= sticky overflow.
  - Register ndigits <= 1 + index of the highest nonzero digit (1 if all zero).
  - done=1 for exactly this cycle; busy=0 from this cycle. Next state IDLE.
- Latency: start accepted at cycle 0 => done=1 at cycle BIN_W+1 (BIN_W SHIFT cycles + 1 FINISH cycle).
  - Back-to-back: a new start is accepted the cycle after FINISH, so the throughput is one result per BIN_W+2 cycles.
- start while busy or in FINISH: ignored, with no queuing and no effect on the current conversion. bin_in changes during busy have no effect.
- Overflow:
  - ovf=1 => bcd_out holds the low DIGITS digits of the true decimal value (modulo 10^DIGITS).
  - ndigits is computed on those digits only.
- Outputs bcd_out/ovf/ndigits change only in FINISH or on reset. They are stable between done pulses.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- BIN_W=16, DIGITS=5. Reset, then start with bin_in=0 => done at cycle 17; bcd_out=20'h00000, ovf=0, ndigits=1; busy high cycles 1..16.
- BIN_W=16, DIGITS=5. bin_in=65535 => bcd_out=20'h65535, ovf=0, ndigits=5. Then bin_in=1234 started the cycle after done => bcd_out=20'h01234, ndigits=4, done 17 cycles after that start.
- BIN_W=16, DIGITS=4. bin_in=65535 => bcd_out=16'h5535, ovf=1, ndigits=4. Then bin_in=9999 => bcd_out=16'h9999, ovf=0.
- BIN_W=16, DIGITS=5. Start bin_in=500, then pulse start with bin_in=777 at cycle 5 while busy => single done at cycle 17 with bcd_out=20'h00500; no second done.
- BIN_W=16, DIGITS=5. Start bin_in=4321, assert Reset_n=0 at cycle 8 for 2 cycles => all outputs 0 immediately, no done pulse. A new start with bin_in=42 => bcd_out=20'h00042, ndigits=2.
- BIN_W=32, DIGITS=10. bin_in=32'hFFFFFFFF => done at cycle 33, bcd_out=40'h4294967295, ovf=0, ndigits=10. Random sweep of 1000 values checked against a reference model.
